// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if
//   One sram-like bus link: a request side (req/wr/size/wstrb/addr/wdata)
//   and a response side (addr_ok/data_ok/rdata).
// Modports
//   master : issues requests (drives req..wdata, receives addr_ok/data_ok/rdata)
//   slave  : serves requests (receives req..wdata, drives addr_ok/data_ok/rdata)
interface sram_bus_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one downstream sram-like port between the fetch requester (inst)
//   and the load/store requester (data). One address handshake per cycle;
//   an in-order tag FIFO remembers who issued each outstanding transaction
//   so every returning data_ok is steered back to its issuer. Zero added
//   latency in either direction.
// Ports
//   clk        : clock
//   reset      : synchronous, active-high reset
//   inst       : fetch requester link (slave side of the link)
//   data       : load/store requester link (slave side of the link)
//   mem        : downstream link (master side of the link)
//   proto_err  : sticky; a response arrived with nothing outstanding
module sram_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    sram_bus_arbiter_if.slave      inst,
    sram_bus_arbiter_if.slave      data,
    sram_bus_arbiter_if.master     mem,
    output logic                   proto_err
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    // The lock keeps the downstream request stable while it waits for
    // mem.addr_ok, so the owner can never switch mid-handshake.
    typedef enum logic [1:0] {
        LOCK_NONE = 2'b00,
        LOCK_INST = 2'b01,
        LOCK_DATA = 2'b10
    } lock_t;

    lock_t                      lock_q, lock_d;
    owner_t                     owner;
    logic [MAX_OUTSTANDING-1:0] tag_q;       // 1 = data, 0 = inst
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic                       full;
    logic                       mem_req;
    logic                       push, pop;
    logic                       head_is_data;

    assign full = (count_q == CNT_W'(MAX_OUTSTANDING));

    // Lock state register
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= LOCK_NONE;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Grant, handshake and lock next-state
    always_comb begin
        owner        = OWN_INST;
        mem_req      = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        head_is_data = 1'b0;
        lock_d       = lock_q;

        case (lock_q)
            LOCK_INST: owner = OWN_INST;
            LOCK_DATA: owner = OWN_DATA;
            default:   owner = data.req ? OWN_DATA : OWN_INST;
        endcase

        // Gating with reset keeps every handshake output quiet in the reset cycle.
        mem_req      = ~reset & ~full & ((owner == OWN_DATA) ? data.req : inst.req);
        push         = mem_req & mem.addr_ok;
        pop          = ~reset & mem.data_ok & (count_q != '0);
        head_is_data = tag_q[rd_ptr_q];

        if (mem_req && !mem.addr_ok) begin
            lock_d = (owner == OWN_DATA) ? LOCK_DATA : LOCK_INST;
        end else if (push) begin
            lock_d = LOCK_NONE;
        end
    end

    assign mem.req   = mem_req;
    assign mem.wr    = (owner == OWN_DATA) ? data.wr    : inst.wr;
    assign mem.size  = (owner == OWN_DATA) ? data.size  : inst.size;
    assign mem.wstrb = (owner == OWN_DATA) ? data.wstrb : inst.wstrb;
    assign mem.addr  = (owner == OWN_DATA) ? data.addr  : inst.addr;
    assign mem.wdata = (owner == OWN_DATA) ? data.wdata : inst.wdata;

    assign inst.addr_ok = push & (owner == OWN_INST);
    assign data.addr_ok = push & (owner == OWN_DATA);
    assign inst.data_ok = pop & ~head_is_data;
    assign data.data_ok = pop &  head_is_data;
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;

    // Tag FIFO, pointers, occupancy and protocol error flag.
    // Pointers wrap naturally because MAX_OUTSTANDING is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= (owner == OWN_DATA);
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (mem.data_ok && (count_q == '0)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter
//   Directed-vector bench for sram_bus_arbiter. Inputs change 1 time unit
//   after each rising edge; outputs are compared 3 units later, well before
//   the next edge. The downstream side is driven directly by the bench.
module tb_sram_bus_arbiter;

    logic clk;
    logic reset;
    logic proto_err;
    int   vectors;
    int   miscompares;

    sram_bus_arbiter_if inst_bus ();
    sram_bus_arbiter_if data_bus ();
    sram_bus_arbiter_if mem_bus ();

    sram_bus_arbiter #(
        .MAX_OUTSTANDING(4),
        .CNT_W          (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .inst     (inst_bus.slave),
        .data     (data_bus.slave),
        .mem      (mem_bus.master),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive_idle();
        inst_bus.req   = 1'b0;
        inst_bus.wr    = 1'b0;
        inst_bus.size  = 2'd2;
        inst_bus.wstrb = 4'hf;
        inst_bus.addr  = 32'h0;
        inst_bus.wdata = 32'h0;
        data_bus.req   = 1'b0;
        data_bus.wr    = 1'b0;
        data_bus.size  = 2'd2;
        data_bus.wstrb = 4'h0;
        data_bus.addr  = 32'h0;
        data_bus.wdata = 32'h0;
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b0;
        mem_bus.rdata   = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        inst_bus.req    = 1'b1;
        mem_bus.addr_ok = 1'b1;
        mem_bus.data_ok = 1'b1;
        settle();
        vectors++; if (mem_bus.req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got %b want 0", mem_bus.req); end
        vectors++; if (inst_bus.addr_ok !== 1'b0) begin miscompares++; $display("FAIL rst_inst_addr_ok got %b want 0", inst_bus.addr_ok); end
        vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b00) begin miscompares++; $display("FAIL rst_data_ok got %b want 00", {inst_bus.data_ok, data_bus.data_ok}); end
        tick();
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL rst_proto_err got %b want 0", proto_err); end
        reset = 1'b0;
        drive_idle();
        settle();
        vectors++; if (mem_bus.req !== 1'b0) begin miscompares++; $display("FAIL rst_idle_mem_req got %b want 0", mem_bus.req); end
        tick();
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL rst_after_proto_err got %b want 0", proto_err); end
    endtask

    task automatic test_single_fetch();
        inst_bus.req    = 1'b1;
        inst_bus.addr   = 32'h1c00_0000;
        mem_bus.addr_ok = 1'b1;
        settle();
        vectors++; if (mem_bus.req !== 1'b1) begin miscompares++; $display("FAIL t1_mem_req got %b want 1", mem_bus.req); end
        vectors++; if (mem_bus.addr !== 32'h1c00_0000) begin miscompares++; $display("FAIL t1_mem_addr got %h want 1c000000", mem_bus.addr); end
        vectors++; if ({inst_bus.addr_ok, data_bus.addr_ok} !== 2'b10) begin miscompares++; $display("FAIL t1_addr_ok got %b want 10", {inst_bus.addr_ok, data_bus.addr_ok}); end
        tick();
        drive_idle();
        settle();
        vectors++; if (mem_bus.req !== 1'b0) begin miscompares++; $display("FAIL t1_idle_mem_req got %b want 0", mem_bus.req); end
        tick();
        mem_bus.data_ok = 1'b1;
        mem_bus.rdata   = 32'h0280_0000;
        settle();
        vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b10) begin miscompares++; $display("FAIL t1_data_ok got %b want 10", {inst_bus.data_ok, data_bus.data_ok}); end
        vectors++; if (inst_bus.rdata !== 32'h0280_0000) begin miscompares++; $display("FAIL t1_rdata got %h want 02800000", inst_bus.rdata); end
        tick();
        drive_idle();
    endtask

    task automatic test_priority();
        inst_bus.req    = 1'b1;
        inst_bus.addr   = 32'h1c00_0040;
        data_bus.req    = 1'b1;
        data_bus.wr     = 1'b1;
        data_bus.wstrb  = 4'h3;
        data_bus.size   = 2'd1;
        data_bus.addr   = 32'h8000_1000;
        data_bus.wdata  = 32'hdead_beef;
        mem_bus.addr_ok = 1'b1;
        settle();
        vectors++; if (mem_bus.addr !== 32'h8000_1000) begin miscompares++; $display("FAIL t2_mem_addr_data got %h want 80001000", mem_bus.addr); end
        vectors++; if ({mem_bus.wr, mem_bus.size, mem_bus.wstrb} !== 7'b1_01_0011) begin miscompares++; $display("FAIL t2_mem_ctl_data got %b want 1010011", {mem_bus.wr, mem_bus.size, mem_bus.wstrb}); end
        vectors++; if (mem_bus.wdata !== 32'hdead_beef) begin miscompares++; $display("FAIL t2_mem_wdata got %h want deadbeef", mem_bus.wdata); end
        vectors++; if ({inst_bus.addr_ok, data_bus.addr_ok} !== 2'b01) begin miscompares++; $display("FAIL t2_addr_ok_first got %b want 01", {inst_bus.addr_ok, data_bus.addr_ok}); end
        tick();
        data_bus.req = 1'b0;
        settle();
        vectors++; if (mem_bus.addr !== 32'h1c00_0040) begin miscompares++; $display("FAIL t2_mem_addr_inst got %h want 1c000040", mem_bus.addr); end
        vectors++; if ({mem_bus.wr, mem_bus.wstrb} !== 5'b0_1111) begin miscompares++; $display("FAIL t2_mem_ctl_inst got %b want 01111", {mem_bus.wr, mem_bus.wstrb}); end
        vectors++; if ({inst_bus.addr_ok, data_bus.addr_ok} !== 2'b10) begin miscompares++; $display("FAIL t2_addr_ok_second got %b want 10", {inst_bus.addr_ok, data_bus.addr_ok}); end
        tick();
        drive_idle();
        mem_bus.data_ok = 1'b1;
        mem_bus.rdata   = 32'h1111_2222;
        settle();
        vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b01) begin miscompares++; $display("FAIL t2_resp1 got %b want 01", {inst_bus.data_ok, data_bus.data_ok}); end
        vectors++; if (data_bus.rdata !== 32'h1111_2222) begin miscompares++; $display("FAIL t2_resp1_rdata got %h want 11112222", data_bus.rdata); end
        tick();
        mem_bus.rdata = 32'h3333_4444;
        settle();
        vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b10) begin miscompares++; $display("FAIL t2_resp2 got %b want 10", {inst_bus.data_ok, data_bus.data_ok}); end
        tick();
        drive_idle();
    endtask

    task automatic test_lock();
        // data waits three cycles, inst joins in the second
        data_bus.req  = 1'b1;
        data_bus.addr = 32'h8000_2000;
        inst_bus.addr = 32'h1c00_0080;
        for (int unsigned c = 0; c < 3; c++) begin
            if (c == 1) inst_bus.req = 1'b1;
            settle();
            vectors++; if (mem_bus.addr !== 32'h8000_2000 || mem_bus.req !== 1'b1) begin miscompares++; $display("FAIL t3_hold_data c%0d got req=%b addr=%h want req=1 addr=80002000", c, mem_bus.req, mem_bus.addr); end
            tick();
        end
        mem_bus.addr_ok = 1'b1;
        settle();
        vectors++; if ({inst_bus.addr_ok, data_bus.addr_ok} !== 2'b01) begin miscompares++; $display("FAIL t3_accept_data got %b want 01", {inst_bus.addr_ok, data_bus.addr_ok}); end
        tick();
        data_bus.req = 1'b0;
        settle();
        vectors++; if ({inst_bus.addr_ok, data_bus.addr_ok} !== 2'b10) begin miscompares++; $display("FAIL t3_accept_inst got %b want 10", {inst_bus.addr_ok, data_bus.addr_ok}); end
        tick();
        drive_idle();
        mem_bus.data_ok = 1'b1;
        settle();
        vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b01) begin miscompares++; $display("FAIL t3_resp1 got %b want 01", {inst_bus.data_ok, data_bus.data_ok}); end
        tick();
        settle();
        vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b10) begin miscompares++; $display("FAIL t3_resp2 got %b want 10", {inst_bus.data_ok, data_bus.data_ok}); end
        tick();
        drive_idle();

        // mirror: inst waits, data joins later and must not steal the lock
        inst_bus.req  = 1'b1;
        inst_bus.addr = 32'h1c00_00c0;
        data_bus.addr = 32'h8000_3000;
        settle();
        vectors++; if (mem_bus.addr !== 32'h1c00_00c0) begin miscompares++; $display("FAIL t3m_first got %h want 1c0000c0", mem_bus.addr); end
        tick();
        data_bus.req = 1'b1;
        settle();
        vectors++; if (mem_bus.addr !== 32'h1c00_00c0) begin miscompares++; $display("FAIL t3m_locked got %h want 1c0000c0", mem_bus.addr); end
        tick();
        mem_bus.addr_ok = 1'b1;
        settle();
        vectors++; if ({inst_bus.addr_ok, data_bus.addr_ok} !== 2'b10) begin miscompares++; $display("FAIL t3m_accept_inst got %b want 10", {inst_bus.addr_ok, data_bus.addr_ok}); end
        tick();
        inst_bus.req = 1'b0;
        settle();
        vectors++; if ({inst_bus.addr_ok, data_bus.addr_ok} !== 2'b01 || mem_bus.addr !== 32'h8000_3000) begin miscompares++; $display("FAIL t3m_accept_data got ok=%b addr=%h want ok=01 addr=80003000", {inst_bus.addr_ok, data_bus.addr_ok}, mem_bus.addr); end
        tick();
        drive_idle();
        mem_bus.data_ok = 1'b1;
        settle();
        vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b10) begin miscompares++; $display("FAIL t3m_resp1 got %b want 10", {inst_bus.data_ok, data_bus.data_ok}); end
        tick();
        settle();
        vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b01) begin miscompares++; $display("FAIL t3m_resp2 got %b want 01", {inst_bus.data_ok, data_bus.data_ok}); end
        tick();
        drive_idle();
    endtask

    task automatic test_full();
        inst_bus.req    = 1'b1;
        mem_bus.addr_ok = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            inst_bus.addr = 32'h1c00_0100 + 32'(i * 4);
            settle();
            vectors++; if (inst_bus.addr_ok !== 1'b1) begin miscompares++; $display("FAIL t4_fill%0d got %b want 1", i, inst_bus.addr_ok); end
            tick();
        end
        settle();
        vectors++; if ({mem_bus.req, inst_bus.addr_ok} !== 2'b00) begin miscompares++; $display("FAIL t4_full got req/ok=%b want 00", {mem_bus.req, inst_bus.addr_ok}); end
        tick();
        // pop at full: no same-cycle push allowed
        mem_bus.data_ok = 1'b1;
        settle();
        vectors++; if ({mem_bus.req, inst_bus.addr_ok, inst_bus.data_ok} !== 3'b001) begin miscompares++; $display("FAIL t4_no_bypass got req/aok/dok=%b want 001", {mem_bus.req, inst_bus.addr_ok, inst_bus.data_ok}); end
        tick();
        inst_bus.req = 1'b0;
        for (int unsigned i = 1; i < 4; i++) begin
            settle();
            vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b10) begin miscompares++; $display("FAIL t4_drain%0d got %b want 10", i, {inst_bus.data_ok, data_bus.data_ok}); end
            tick();
        end
        mem_bus.data_ok = 1'b0;
        inst_bus.req    = 1'b1;
        settle();
        vectors++; if (inst_bus.addr_ok !== 1'b1) begin miscompares++; $display("FAIL t4_regrant got %b want 1", inst_bus.addr_ok); end
        tick();
        drive_idle();
        mem_bus.data_ok = 1'b1;
        settle();
        vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b10) begin miscompares++; $display("FAIL t4_regrant_resp got %b want 10", {inst_bus.data_ok, data_bus.data_ok}); end
        tick();
        drive_idle();
    endtask

    task automatic test_push_pop_wrap();
        logic [9:0] pat;
        logic       exp_q[$];
        logic       head;
        pat = 10'b01_1010_0111;   // bit i = owner of transaction i (1 = data)
        for (int unsigned i = 0; i < 12; i++) begin
            drive_idle();
            if (i < 10) begin
                mem_bus.addr_ok = 1'b1;
                if (pat[i]) data_bus.req = 1'b1;
                else        inst_bus.req = 1'b1;
            end
            head = 1'b0;
            if (i >= 2) begin
                mem_bus.data_ok = 1'b1;
                head = exp_q[0];
            end
            settle();
            if (i < 10) begin
                vectors++; if ({inst_bus.addr_ok, data_bus.addr_ok} !== {~pat[i], pat[i]}) begin miscompares++; $display("FAIL t5_push%0d got %b want %b", i, {inst_bus.addr_ok, data_bus.addr_ok}, {~pat[i], pat[i]}); end
            end
            if (i >= 2) begin
                vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== {~head, head}) begin miscompares++; $display("FAIL t5_pop%0d got %b want %b", i, {inst_bus.data_ok, data_bus.data_ok}, {~head, head}); end
                void'(exp_q.pop_front());
            end
            if (i < 10) exp_q.push_back(pat[i]);
            tick();
        end
        drive_idle();
    endtask

    task automatic test_proto_err();
        mem_bus.data_ok = 1'b1;
        settle();
        vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b00) begin miscompares++; $display("FAIL t6_no_pulse got %b want 00", {inst_bus.data_ok, data_bus.data_ok}); end
        tick();
        drive_idle();
        for (int unsigned i = 0; i < 3; i++) begin
            settle();
            vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL t6_sticky%0d got %b want 1", i, proto_err); end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL t6_cleared got %b want 0", proto_err); end

        // reset with one transaction in flight discards its tag
        inst_bus.req    = 1'b1;
        mem_bus.addr_ok = 1'b1;
        tick();
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_bus.data_ok = 1'b1;
        settle();
        vectors++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b00) begin miscompares++; $display("FAIL t6_stale_tag got %b want 00", {inst_bus.data_ok, data_bus.data_ok}); end
        tick();
        drive_idle();
        settle();
        vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL t6_stale_err got %b want 1", proto_err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive_idle();
        #1;
        test_reset();
        test_single_fetch();
        test_priority();
        test_lock();
        test_full();
        test_push_pop_wrap();
        test_proto_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
